multibyte_add_seq: RTL and testbench
====================================

Name: multibyte_add_seq

Overview:
- Sequencer that performs wide add/subtract on NBYTES-byte operands.
- Time-multiplexes a single 8-bit ripple-carry adder, one byte per cycle, least-significant byte first.
- The carry is chained through a registered carry flop between cycles.
- Sits between a request source and a result consumer; each side has an independent valid/ready handshake.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..16.
- CNT_W, $clog2(NBYTES), width of the byte index counter.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, sequencer can accept a request.
- op_a, input, 8*NBYTES, operand A.
- op_b, input, 8*NBYTES, operand B.
- cin, input, 1, carry-in for add mode; ignored when sub=1.
- sub, input, 1, 1 = compute A - B (B inverted, carry-in forced to 1).
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, 8*NBYTES, sum/difference.
- cout, output, 1, final carry out; in sub mode, 1 means no borrow.
- ovf, output, 1, signed overflow of the full-width operation.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, byte index=0, carry flop=0.
  - result=0, cout=0, ovf=0, out_valid=0, in_ready=0 during reset.
  - in_ready rises in the first cycle after rst_n is sampled high.
  - Reset mid-operation aborts the job silently; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture op_a; capture op_b inverted if sub=1; carry flop <= (sub ? 1 : cin); index <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, feed captured byte[index] of A and B plus the carry flop to the adder.
  - Write the sum into result byte[index]; carry flop <= adder cout; index++.
  - When index==NBYTES-1: cout <= adder cout; ovf <= a7 ^ b7eff ^ s7 ^ adder cout, taken on the MSB byte (b7eff = B bit after inversion); go to DONE.
- DONE:
  - out_valid=1; result, cout and ovf are held stable.
  - On out_ready: out_valid drops next cycle, state -> IDLE.
  - out_ready low holds DONE indefinitely (back-pressure); no new request is accepted.
- Latency: handshake accepted at edge T -> out_valid high from edge T+NBYTES. Minimum request-to-request spacing is NBYTES+2 cycles.
- Boundary conditions:
  - in_valid while not in IDLE: ignored. The requester must hold request data until in_ready.
  - out_ready asserted outside DONE: no effect.
  - Simultaneous in_valid with out_ready in DONE: only the output handshake completes; the request is accepted the following cycle in IDLE.
- Width rules:
  - All arithmetic is modulo 2^(8*NBYTES).
  - Sub mode: result = A + ~B + 1.
  - cout is bit 8*NBYTES of the unsigned sum.
- Outputs are registered; no combinational path from inputs to outputs except in_ready, which is decoded from state only.

Decomposition:
- Shared package adder_pkg: FSM state enum (IDLE, RUN, DONE); localparam BYTE_W=8.
- Sub-module: one instance of the team's existing 8-bit ripple-carry adder (simple_8bit_adder: a, b, cin, sum, cout) as the per-byte datapath.
- The sequencer itself holds only:
  - operand registers;
  - carry flop;
  - index counter;
  - byte-addressed result write mux;
  - FSM.

Test Plan:
- NBYTES=4, add, A=0x0000_00FF, B=0x0000_0001, cin=0 -> result 0x0000_0100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- Add, A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> result 0x0000_0000, cout=1, ovf=0; confirms carry ripple across all 4 bytes.
- Sub, A=0x0000_0005, B=0x0000_0007 -> result 0xFFFF_FFFE, cout=0, ovf=0. Then sub, A=0x8000_0000, B=1 -> result 0x7FFF_FFFF, cout=1, ovf=1.
- Back-pressure: complete A=0x7FFF_FFFF + B=1 with out_ready=0 for 10 cycles -> out_valid stays 1; result 0x8000_0000 and ovf=1 stay stable; in_ready=0 throughout; the in_valid pulse during the hold is ignored.
- Reset mid-RUN: assert rst_n=0 at the 2nd RUN cycle -> next cycle out_valid=0, result=0, cout=0, ovf=0. After release, in_ready=1 and a fresh 0x1 + 0x1 returns 0x2.
- Back-to-back: two queued requests (in_valid held) with out_ready=1 -> accepts exactly NBYTES+2 cycles apart; each result matches a reference model over 1000 random add/sub vectors.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the multibyte add/subtract sequencer.
// FSM encoding, datapath byte width and the overflow helper.
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow from the MSB byte: carry into bit 7 xor carry out.
    function automatic logic ovf_calc(
        input logic a7,
        input logic b7,
        input logic s7,
        input logic co
    );
        return a7 ^ b7 ^ s7 ^ co;
    endfunction

endpackage

// File: rtl/simple_8bit_adder.sv
// 8-bit ripple-carry adder, the per-byte datapath slice.
// Pure combinational; carry propagates bit by bit.
module simple_8bit_adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[8];
    end

endmodule

// File: rtl/multibyte_add_seq.sv
// Wide add/subtract sequencer: one byte per cycle, LSB first,
// through a single 8-bit adder with a registered carry chain.
module multibyte_add_seq
    import adder_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int CNT_W  = $clog2(NBYTES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NBYTES-1:0]      op_a,
    input  logic [8*NBYTES-1:0]      op_b,
    input  logic                     cin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NBYTES-1:0]      result,
    output logic                     cout,
    output logic                     ovf
);

    localparam int W = BYTE_W * NBYTES;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

    state_t             state;
    state_t             state_nx;
    logic               rdy_en;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       res_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   idx;

    logic [BYTE_W-1:0]  a_byte;
    logic [BYTE_W-1:0]  b_byte;
    logic [BYTE_W-1:0]  s_byte;
    logic               add_co;
    logic               accept;
    logic               last;
    logic               in_run;

    assign a_byte = a_q[{idx, 3'b000} +: BYTE_W];
    assign b_byte = b_q[{idx, 3'b000} +: BYTE_W];
    assign accept = in_valid && in_ready;
    assign in_run = (state == RUN);
    assign last   = in_run && (idx == LAST);

    simple_8bit_adder u_add (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .sum  (s_byte),
        .cout (add_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            state == IDLE: if (accept)    state_nx = RUN;
            state == RUN:  if (last)      state_nx = DONE;
            state == DONE: if (out_ready) state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // in_ready stays low for the whole reset cycle and rises one
    // cycle after rst_n is first sampled high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (1'b1)
            state == IDLE: in_ready  = rdy_en;
            state == DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub | cin;
            idx     <= '0;
        end else if (in_run) begin
            res_q[{idx, 3'b000} +: BYTE_W] <= s_byte;
            carry_q <= add_co;
            idx     <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout_q <= add_co;
                ovf_q  <= ovf_calc(a_byte[BYTE_W-1], b_byte[BYTE_W-1],
                                   s_byte[BYTE_W-1], add_co);
            end
        end
    end

    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq.
// Expected results queued at accept, compared at output handshake.
module tb_multibyte_add_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   nchecks  = 0;
    int   nerrors  = 0;
    int   cyc      = 0;
    int   last_acc = -1;
    bit   gap_on   = 1'b0;

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic c,
                                   input logic s);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   full;
        be   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s | c)};
        e.res = full[W-1:0];
        e.co  = full[W];
        e.ov  = (a[W-1] == be[W-1]) && (e.res[W-1] != a[W-1]);
        e.acc = 0;
        return e;
    endfunction

    // Called on a negedge; returns on the negedge after acceptance.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s,
                        input exp_t e, input bit hold);
        int n = 0;
        op_a     = a;
        op_b     = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        if (gap_on && last_acc >= 0)
            check("accept_gap", e.acc - last_acc, NB + 2);
        last_acc = e.acc;
        sb.push_back(e);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    // Monitor samples a little after the negedge so stimulus set on
    // the negedge is already visible.
    initial begin
        exp_t e;
        bit   prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb.size() == 0)
                        check("spurious_out", 1, 0);
                    else
                        check("latency", cyc - sb[0].acc, NB);
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("cout", cout, e.co);
                    check("ovf", ovf, e.ov);
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        int           n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        e.res = 32'h0000_0100; e.co = 0; e.ov = 0; e.acc = 0;
        send(32'h0000_00FF, 32'h0000_0001, 0, 0, e, 0);
        e.res = 32'h0000_0000; e.co = 1; e.ov = 0;
        send(32'hFFFF_FFFF, 32'h0000_0000, 1, 0, e, 0);
        e.res = 32'hFFFF_FFFE; e.co = 0; e.ov = 0;
        send(32'h0000_0005, 32'h0000_0007, 0, 1, e, 0);
        e.res = 32'h7FFF_FFFF; e.co = 1; e.ov = 1;
        send(32'h8000_0000, 32'h0000_0001, 0, 1, e, 0);
        drain();

        out_ready = 1'b0;
        e.res = 32'h8000_0000; e.co = 0; e.ov = 1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, e, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_result", result, 32'h8000_0000);
            check("bp_ovf", ovf, 1);
            check("bp_in_ready", in_ready, 0);
            if (i == 3) begin
                op_a     = 32'h1234_5678;
                op_b     = 32'h1111_1111;
                in_valid = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();

        e.res = 32'h0404_0404; e.co = 0; e.ov = 0;
        send(32'h0303_0303, 32'h0101_0101, 0, 0, e, 0);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_up", in_ready, 1);
        e.res = 32'h0000_0002; e.co = 0; e.ov = 0;
        send(32'h0000_0001, 32'h0000_0001, 0, 0, e, 0);
        drain();

        gap_on   = 1'b1;
        last_acc = -1;
        for (int k = 0; k < 1000; k++) begin
            for (int j = 0; j < NB; j++) begin
                a[j*8 +: 8] = 8'($urandom_range(0, 255));
                b[j*8 +: 8] = 8'($urandom_range(0, 255));
            end
            if (k % 50 == 7)  a = '1;
            if (k % 50 == 13) b = '1;
            c = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            send(a, b, c, s, model(a, b, c, s), k != 999);
        end
        in_valid = 1'b0;
        gap_on   = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
